// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the ALU and data-memory load paths.
// One-entry buffer per requester; round-robin on contention, age order on same-register collisions.
module rf_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_reg,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     dm_valid,
  output logic                     dm_ready,
  input  logic [ADDR_W-1:0]        dm_reg,
  input  logic [DATA_W-1:0]        dm_data,
  output logic                     reg_write,
  output logic [ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data,
  output logic [(1<<ADDR_W)-1:0]   pending
);

  localparam int unsigned NREG = 1 << ADDR_W;

  logic              alu_full, dm_full;
  logic              alu_older, dm_older;
  logic              prio;
  logic [ADDR_W-1:0] alu_reg_q, dm_reg_q;
  logic [DATA_W-1:0] alu_data_q, dm_data_q;

  logic grant_alu, grant_dm, grant_any;
  logic alu_load, dm_load;
  logic alu_full_nxt, dm_full_nxt;

  // Grant from buffer flops only, so ready never depends on valid
  always_comb begin
    grant_alu = 1'b0;
    grant_dm  = 1'b0;
    if (alu_full && dm_full) begin
      if (alu_reg_q == dm_reg_q) grant_dm = dm_older || !alu_older;
      else                       grant_dm = !prio;
      grant_alu = !grant_dm;
    end else begin
      grant_alu = alu_full;
      grant_dm  = dm_full;
    end
  end

  assign grant_any = grant_alu || grant_dm;
  assign alu_ready = !alu_full || grant_alu;
  assign dm_ready  = !dm_full  || grant_dm;

  // Writes to register 0 complete the handshake but never occupy a buffer
  assign alu_load = alu_valid && alu_ready && (alu_reg != '0);
  assign dm_load  = dm_valid  && dm_ready  && (dm_reg  != '0);

  assign alu_full_nxt = alu_load || (alu_full && !grant_alu);
  assign dm_full_nxt  = dm_load  || (dm_full  && !grant_dm);

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_full   <= 1'b0;
      dm_full    <= 1'b0;
      alu_older  <= 1'b0;
      dm_older   <= 1'b0;
      prio       <= 1'b0;
      alu_reg_q  <= '0;
      dm_reg_q   <= '0;
      alu_data_q <= '0;
      dm_data_q  <= '0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      alu_full <= alu_full_nxt;
      dm_full  <= dm_full_nxt;

      if (alu_load) begin
        alu_reg_q  <= alu_reg;
        alu_data_q <= alu_data;
      end
      if (dm_load) begin
        dm_reg_q  <= dm_reg;
        dm_data_q <= dm_data;
      end

      // A fresh entry is younger than whatever stays buffered beside it
      if (alu_load && dm_load) begin
        dm_older  <= 1'b1;
        alu_older <= 1'b0;
      end else if (alu_load) begin
        alu_older <= 1'b0;
        dm_older  <= dm_full_nxt;
      end else if (dm_load) begin
        dm_older  <= 1'b0;
        alu_older <= alu_full_nxt;
      end

      if (grant_dm)       prio <= 1'b1;
      else if (grant_alu) prio <= 1'b0;

      reg_write <= grant_any;
      if (grant_dm) begin
        write_reg  <= dm_reg_q;
        write_data <= dm_data_q;
      end else if (grant_alu) begin
        write_reg  <= alu_reg_q;
        write_data <= alu_data_q;
      end
    end
  end

  // Registers with a write buffered or on the output stage
  always_comb begin
    pending = '0;
    if (alu_full)  pending[alu_reg_q] = 1'b1;
    if (dm_full)   pending[dm_reg_q]  = 1'b1;
    if (reg_write) pending[write_reg] = 1'b1;
    pending[0] = 1'b0;
  end

  logic unused_nreg;
  assign unused_nreg = (NREG == 0);

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-port arbiter for the 32x32 register file. It shares the single write port between the ALU result path and the data-memory load path. Each requester gets a one-entry holding buffer and a valid/ready handshake. Contention is resolved round-robin, except that same-register collisions are resolved by age. The block drives `reg_write`, `write_reg` and `write_data` of the register file from registered outputs, and exports a pending-write mask that hazard logic uses to stall reads of registers with writes still in flight.

## Interface
- `DATA_W`, default 32: write data width.
- `ADDR_W`, default 5: register index width; the register count is 2^ADDR_W.
- `clk`  in  1  rising-edge clock shared with the register file.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `alu_valid`  in  1  ALU result offered.
- `alu_ready`  out  1  ALU buffer can accept this cycle.
- `alu_reg`  in  ADDR_W  ALU destination register.
- `alu_data`  in  DATA_W  ALU result.
- `dm_valid`  in  1  load result offered.
- `dm_ready`  out  1  DM buffer can accept this cycle.
- `dm_reg`  in  ADDR_W  load destination register.
- `dm_data`  in  DATA_W  load data.
- `reg_write`  out  1  write enable to the register file.
- `write_reg`  out  ADDR_W  register file write index.
- `write_data`  out  DATA_W  register file write data.
- `pending`  out  2^ADDR_W  bit r is set while a write to register r is buffered or presented on the output.

## Operation
- State:
  - per requester: `full`, `reg`, `data`, and a 1-bit age stamp `older`;
  - a priority pointer `prio` (0 = DM first, 1 = ALU first);
  - output registers.
- Acceptance:
  - A handshake completes when `x_valid && x_ready` at a rising edge.
  - `x_ready = !full_x || grant_x`. `grant_x` depends only on flops, so there is no combinational path from valid to ready.
  - An accepted request with reg == 0 completes the handshake but is discarded: the buffer is not loaded and no write is issued.
- Grant (combinational from the buffer flops):
  - Neither buffer full: no grant.
  - Exactly one buffer full: grant it.
  - Both full, `alu.reg != dm.reg`: grant DM if `prio == 0`, else ALU.
  - Both full, same reg: grant the buffer whose `older` bit is set.
- Age stamp:
  - A buffer loaded while the other is already full gets `older = 0`, and the other gets `older = 1`.
  - When both load in the same cycle, DM is marked older, so DM writes first and ALU's value is the one that remains.
- Pointer:
  - On any grant made while both buffers are full, `prio` points to the non-granted requester.
  - On a single-buffer grant, `prio` points to the other requester.
- Drain: the granted buffer empties at the edge. If that requester also handshakes in the same cycle, the buffer reloads with the new request instead of emptying.
- Output register:
  - Each edge, `reg_write <= grant_any`, and `write_reg` / `write_data` take the granted entry.
  - `write_reg` and `write_data` hold their last values when `reg_write = 0`.
- Pending mask: the OR of one-hot(`alu.reg`) if `alu.full`, one-hot(`dm.reg`) if `dm.full`, and one-hot(`write_reg`) if `reg_write`. Bit 0 is never set.

## Timing
- Reset (edge with `rst = 1`):
  - both buffers empty, `older = 0`, `prio = 0`;
  - `reg_write = 0`, `write_reg = 0`, `write_data = 0`, `pending = 0`;
  - `alu_ready = dm_ready = 1` in the cycle after reset.
- Reset mid-operation: buffered and output entries are discarded. No write is issued on the edges following reset.
- Latency: request accepted at edge N → `reg_write` high after edge N+1 → register file updated at edge N+2.
- Throughput:
  - A single active requester sustains one write per cycle.
  - Under sustained contention each requester gets one write every 2 cycles, and `ready` deasserts on the non-granted side.
- `pending[r]` rises the cycle after acceptance and falls the cycle after the register file write edge. It is never low while a write to r is in flight.

## Test plan
- Reset then idle:
  - `alu_ready = dm_ready = 1`, `reg_write = 0`, `pending = 0`.
  - Assert `rst` while both buffers hold data: all flops clear, and no write occurs.
- Single ALU stream:
  - Stimulus: `alu_valid` held, regs 1, 2, 3, data 0xA1, 0xA2, 0xA3 on consecutive edges.
  - Response: `reg_write` high on 3 consecutive cycles starting 1 cycle after the first accept, with `write_reg` 1, 2, 3 and the matching data. `alu_ready` stays 1.
- Contention, different regs:
  - Stimulus: both valid every cycle, ALU reg 4, DM reg 5.
  - Response: writes alternate DM, ALU, DM, ALU…, first DM (`prio = 0` after reset). Each side's `ready` is low on alternate cycles.
- Same-register collision:
  - Case 1: ALU and DM both write reg 7 in the same cycle, ALU data 0x11, DM data 0x22. Response: writes 0x22 then 0x11, and register 7 ends at 0x11.
  - Case 2: DM accepted one cycle before ALU. Response: DM writes first regardless of `prio`.
- Zero register:
  - Stimulus: ALU request to reg 0 with data 0xFFFF_FFFF.
  - Response: handshake completes, `reg_write` never asserts, and `pending` stays 0.
- Pending mask:
  - Stimulus: DM write to reg 9.
  - Response: `pending[9]` set from the cycle after accept through the cycle `reg_write = 1`, then clear. A simultaneous ALU write to reg 9 keeps the bit set until both writes retire.
